// File: rtl/multicycle_controller.sv
// Control unit for the RISC-V multicycle core: Moore main FSM with ALU and
// immediate decoders driving every datapath select and write enable.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state, next_state, cur;
  logic [1:0] alu_op;
  logic       branch, pc_update;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE:  case (op)
                 OP_LW, OP_SW: next_state = MEMADR;
                 OP_R:         next_state = EXECR;
                 OP_I:         next_state = EXECI;
                 OP_BEQ:       next_state = BEQ;
                 OP_JAL:       next_state = JAL;
                 default:      next_state = FETCH;
               endcase
      MEMADR:  next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: next_state = MEMWB;
      EXECR,
      EXECI,
      JAL:     next_state = ALUWB;
      default: next_state = FETCH;
    endcase
  end

  // Outputs read as FETCH for as long as reset is held, whatever the register holds.
  assign cur = reset ? FETCH : state;

  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    alu_op    = 2'b00;
    branch    = 1'b0;
    pc_update = 1'b0;
    case (cur)
      FETCH:    begin IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update = 1'b1; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      EXECR:    begin ALUSrcA = 2'b10; alu_op = 2'b10; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = 2'b10; end
      ALUWB:    RegWrite = 1'b1;
      BEQ:      begin ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      default:  ;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);

  // Subtract only for R-type with funct7b5 set; addi's funct7b5 is immediate bits.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01:   ALUControl = 3'b001;
      2'b10:   case (funct3)
                 3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                 3'b010:  ALUControl = 3'b101;
                 3'b110:  ALUControl = 3'b011;
                 3'b111:  ALUControl = 3'b010;
                 default: ALUControl = 3'b000;
               endcase
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through
// its state sequence and compares the full control word every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite, PCWrite, RegWrite, MemWrite;

  int errors = 0;
  int checks = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite)
  );

  always #5 clk = ~clk;

  // Control word: ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl, IR, PCW, RegW, MemW
  logic [15:0] ctl;
  assign ctl = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                IRWrite, PCWrite, RegWrite, MemWrite};

  function automatic logic [15:0] pk(input logic [1:0] imm, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] res,
                                     input logic adr, input logic [2:0] alu,
                                     input logic ir, input logic pcw,
                                     input logic rw, input logic mw);
    return {imm, a, b, res, adr, alu, ir, pcw, rw, mw};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] f;
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    reset = 1'b1;
    f = pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (ctl !== f) begin
        errors++;
        $display("FAIL reset_held[%0d]: got %h expected %h", i, ctl, f);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ResultSrc, ALUSrcB, IRWrite, PCWrite, AdrSrc, RegWrite, MemWrite} !== 9'b10_10_1_1_0_0_0) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", ctl, f);
    end
  endtask

  task automatic test_lw();
    logic [15:0] e [5];
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b1;
    e[0] = pk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); // DECODE
    e[1] = pk(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); // MEMADR
    e[2] = pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); // MEMREAD
    e[3] = pk(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0); // MEMWB
    e[4] = pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0); // FETCH
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL lw[%0d]: got %h expected %h", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [15:0] e [4];
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    e[0] = pk(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    e[1] = pk(2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    e[2] = pk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1); // MEMWRITE
    e[3] = pk(2'b01, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL sw[%0d]: got %h expected %h", i, ctl, e[i]);
      end
    end
  endtask

  // One R/I-type instruction: DECODE, EXEC, ALUWB, FETCH.
  task automatic test_alu(input string name, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [1:0] srcb, input logic [2:0] alu);
    logic [15:0] e [4];
    op = o; funct3 = f3; funct7b5 = f7; Zero = 1'b1;
    e[0] = pk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    e[1] = pk(2'b00, 2'b10, srcb,  2'b00, 1'b0, alu,    1'b0, 1'b0, 1'b0, 1'b0);
    e[2] = pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    e[3] = pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_beq(input logic z);
    logic [15:0] e [3];
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = z;
    e[0] = pk(2'b10, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    e[1] = pk(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, z,    1'b0, 1'b0);
    e[2] = pk(2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL beq_z%0d[%0d]: got %h expected %h", z, i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_jal();
    logic [15:0] e [4];
    op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    e[0] = pk(2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    e[1] = pk(2'b11, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0); // JAL
    e[2] = pk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0); // ALUWB
    e[3] = pk(2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL jal[%0d]: got %h expected %h", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_unsupported();
    logic [15:0] e [2];
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
    e[0] = pk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    e[1] = pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL unsupported[%0d]: got %h expected %h", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e [3];
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    step(); step(); step();                 // DECODE, MEMADR, MEMREAD
    checks++;
    if (AdrSrc !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_memread: got AdrSrc %b expected 1", AdrSrc);
    end
    reset = 1'b1;
    e[0] = pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0); // FETCH
    e[1] = pk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); // DECODE
    e[2] = pk(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); // MEMADR
    step();
    checks++;
    if (ctl !== e[0]) begin
      errors++;
      $display("FAIL reset_mid_fetch: got %h expected %h", ctl, e[0]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== e[0]) begin
      errors++;
      $display("FAIL reset_mid_release: got %h expected %h", ctl, e[0]);
    end
    for (int i = 1; i < 3; i++) begin
      step();
      checks++;
      if (ctl !== e[i]) begin
        errors++;
        $display("FAIL reset_mid_restart[%0d]: got %h expected %h", i, ctl, e[i]);
      end
    end
    step(); step(); step();                 // MEMREAD, MEMWB, FETCH
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu("sub",  7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
    test_alu("add",  7'b0110011, 3'b000, 1'b0, 2'b00, 3'b000);
    test_alu("slt",  7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101);
    test_alu("and",  7'b0110011, 3'b111, 1'b0, 2'b00, 3'b010);
    test_alu("addi", 7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);
    test_alu("ori",  7'b0010011, 3'b110, 1'b0, 2'b01, 3'b011);
    test_alu("slti", 7'b0010011, 3'b010, 1'b1, 2'b01, 3'b101);
    test_alu("f3_other", 7'b0110011, 3'b001, 1'b1, 2'b00, 3'b000);
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw();
    test_jal();
    test_unsupported();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
